// File: rtl/wr_line_buf.sv
// Video line writer: packs 16-bit pixels into 128-bit words, ping-pongs
// whole lines through two buffer halves and bursts each line to DDR.
module wr_line_buf #(
  parameter int          ADDR_WIDTH      = 27,
  parameter logic [31:0] ADDR_OFFSET     = 32'h0000_0000,
  parameter int          H_NUM           = 1920,
  parameter int          V_NUM           = 1080,
  parameter int          DQ_WIDTH        = 16,
  parameter int          LEN_WIDTH       = 16,
  parameter int          PIX_WIDTH       = 16,
  parameter int          LINE_ADDR_WIDTH = 19
) (
  input  logic                    ddr_clk,
  input  logic                    ddr_rstn,
  input  logic                    wr_fsync,
  input  logic                    wr_en,
  input  logic [PIX_WIDTH-1:0]    wr_data,
  input  logic                    init_done,
  output logic                    ddr_wreq,
  output logic [ADDR_WIDTH-1:0]   ddr_waddr,
  output logic [LEN_WIDTH-1:0]    ddr_wr_len,
  input  logic                    ddr_wrdy,
  input  logic                    ddr_wdata_req,
  output logic [8*DQ_WIDTH-1:0]   ddr_wdata,
  input  logic                    ddr_wdone,
  output logic                    frame_done,
  output logic                    overflow
);

  localparam int DW        = 8 * DQ_WIDTH;
  localparam int PPW       = DW / PIX_WIDTH;
  localparam int PCW       = $clog2(PPW);
  localparam int WPL       = H_NUM * PIX_WIDTH / DW;
  localparam int LINE_STEP = WPL * 8;
  localparam int LCW       = $clog2(V_NUM + 1);
  localparam int LAW       = LINE_ADDR_WIDTH;

  localparam logic [7:0]            WPL_M1 = 8'(WPL - 1);
  localparam logic [PCW-1:0]        PIX_M1 = PCW'(PPW - 1);
  localparam logic [LCW-1:0]        VN_M1  = LCW'(V_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] OFS    = ADDR_WIDTH'(ADDR_OFFSET);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DATA
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic                  r_fsync_d;
  logic                  r_frame_cnt;
  logic [LAW-1:0]        r_line_addr;
  logic                  r_active;
  logic [DW-PIX_WIDTH-1:0] r_pix;
  logic [PCW-1:0]        r_pix_cnt;
  logic [7:0]            r_word_cnt;
  logic [LCW-1:0]        r_line_cnt;
  logic [LCW-1:0]        r_done_cnt;
  logic                  r_drop;
  logic                  r_wr_half;
  logic                  r_rd_half;
  logic [1:0]            r_full;
  logic [1:0]            w_full_nx;
  logic [7:0]            r_rd_idx;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DW-1:0]         r_wdata;
  logic                  r_frame_done;
  logic                  r_overflow;

  logic [DW-1:0]         r_mem [0:511];

  logic                  w_fsync_rise;
  logic                  w_pix_ok;
  logic                  w_word_we;
  logic                  w_line_end;
  logic                  w_half_busy;
  logic                  w_mem_we;
  logic                  w_line_ok;
  logic                  w_wdone;
  logic                  w_rd_fire;
  logic                  w_draining;
  logic [DW-1:0]         w_word;
  logic [ADDR_WIDTH-1:0] w_req_addr;

  assign w_fsync_rise = wr_fsync & ~r_fsync_d;
  assign w_pix_ok     = r_active & wr_en & ~w_fsync_rise;
  assign w_word_we    = w_pix_ok & (r_pix_cnt == PIX_M1);
  assign w_line_end   = w_word_we & (r_word_cnt == WPL_M1);
  assign w_word       = {wr_data, r_pix};
  assign w_half_busy  = r_full[r_wr_half];
  // once any word of a line hits a busy half the whole line is discarded
  assign w_mem_we     = w_word_we & ~w_half_busy & ~r_drop;
  assign w_line_ok    = w_line_end & ~w_half_busy & ~r_drop;
  assign w_wdone      = (r_state == S_DATA) & ddr_wdone;
  assign w_rd_fire    = (r_state == S_DATA) & ddr_wdata_req;
  assign w_draining   = (r_state != S_IDLE);

  assign w_req_addr = ({r_frame_cnt, {(ADDR_WIDTH-1){1'b0}}}
                      | ADDR_WIDTH'(r_line_addr)) + OFS;

  assign ddr_wreq   = (r_state == S_REQ);
  assign ddr_waddr  = r_waddr;
  assign ddr_wr_len = LEN_WIDTH'(WPL);
  assign ddr_wdata  = r_wdata;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (r_full[r_rd_half] && init_done) w_state_nx = S_REQ;
      S_REQ:  if (ddr_wrdy)  w_state_nx = S_DATA;
      S_DATA: if (ddr_wdone) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_full_nx = r_full;
    if (w_wdone) w_full_nx[r_rd_half] = 1'b0;
    if (w_line_ok) w_full_nx[r_wr_half] = 1'b1;
    // a half still feeding the controller survives a frame restart
    if (w_fsync_rise && !(w_draining && (r_wr_half == r_rd_half)))
      w_full_nx[r_wr_half] = 1'b0;
  end

  always_ff @(posedge ddr_clk) begin
    if (w_mem_we) r_mem[{r_wr_half, r_word_cnt}] <= w_word;
  end

  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      r_state      <= S_IDLE;
      r_fsync_d    <= 1'b0;
      r_frame_cnt  <= 1'b0;
      r_line_addr  <= '0;
      r_active     <= 1'b0;
      r_pix        <= '0;
      r_pix_cnt    <= '0;
      r_word_cnt   <= '0;
      r_line_cnt   <= '0;
      r_done_cnt   <= '0;
      r_drop       <= 1'b0;
      r_wr_half    <= 1'b0;
      r_rd_half    <= 1'b0;
      r_full       <= '0;
      r_rd_idx     <= '0;
      r_waddr      <= OFS;
      r_wdata      <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_fsync_d    <= wr_fsync;
      r_full       <= w_full_nx;
      r_frame_done <= 1'b0;

      if (r_state == S_IDLE && w_state_nx == S_REQ)
        r_waddr <= w_req_addr;

      if (r_state == S_REQ && w_state_nx == S_DATA)
        r_rd_idx <= '0;
      else if (w_rd_fire)
        r_rd_idx <= r_rd_idx + 1'b1;

      if (w_rd_fire) r_wdata <= r_mem[{r_rd_half, r_rd_idx}];
      if (w_wdone) r_rd_half <= ~r_rd_half;

      if (w_fsync_rise) begin
        r_frame_cnt <= ~r_frame_cnt;
        r_line_addr <= '0;
        r_pix_cnt   <= '0;
        r_word_cnt  <= '0;
        r_line_cnt  <= '0;
        r_done_cnt  <= '0;
        r_overflow  <= 1'b0;
        r_drop      <= 1'b0;
        r_active    <= 1'b1;
      end else begin
        if (w_wdone) begin
          r_line_addr  <= r_line_addr + LAW'(LINE_STEP);
          r_done_cnt   <= r_done_cnt + 1'b1;
          r_frame_done <= (r_done_cnt == VN_M1);
        end
        if (w_pix_ok) begin
          r_pix     <= w_word[DW-1:PIX_WIDTH];
          r_pix_cnt <= r_pix_cnt + 1'b1;
          if (w_word_we) begin
            r_word_cnt <= w_line_end ? 8'd0 : r_word_cnt + 1'b1;
            if (w_half_busy) r_drop <= 1'b1;
          end
          if (w_line_end) begin
            r_drop     <= 1'b0;
            r_line_cnt <= r_line_cnt + 1'b1;
            if (r_line_cnt == VN_M1) r_active <= 1'b0;
            if (w_line_ok) r_wr_half  <= ~r_wr_half;
            else           r_overflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wr_line_buf.sv
// Directed bench for wr_line_buf: packing, handshake, overflow,
// frame sequencing, fsync/wdone collision, init gating and reset.
module tb_wr_line_buf;

  logic          ddr_clk = 1'b0;
  logic          ddr_rstn;
  logic          wr_fsync;
  logic          wr_en;
  logic [15:0]   wr_data;
  logic          init_done;
  logic          ddr_wreq;
  logic [26:0]   ddr_waddr;
  logic [15:0]   ddr_wr_len;
  logic          ddr_wrdy;
  logic          ddr_wdata_req;
  logic [127:0]  ddr_wdata;
  logic          ddr_wdone;
  logic          frame_done;
  logic          overflow;

  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;
  int fd_cnt = 0;
  logic [127:0] beats [0:239];

  always #5 ddr_clk = ~ddr_clk;

  wr_line_buf #(.V_NUM(4)) dut (
    .ddr_clk       (ddr_clk),
    .ddr_rstn      (ddr_rstn),
    .wr_fsync      (wr_fsync),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .init_done     (init_done),
    .ddr_wreq      (ddr_wreq),
    .ddr_waddr     (ddr_waddr),
    .ddr_wr_len    (ddr_wr_len),
    .ddr_wrdy      (ddr_wrdy),
    .ddr_wdata_req (ddr_wdata_req),
    .ddr_wdata     (ddr_wdata),
    .ddr_wdone     (ddr_wdone),
    .frame_done    (frame_done),
    .overflow      (overflow)
  );

  always @(negedge ddr_clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_word(input int b, input int j);
    logic [127:0] w;
    for (int k = 0; k < 8; k++) w[16*k +: 16] = 16'(b + 8*j + k);
    return w;
  endfunction

  task automatic fsync_pulse();
    @(negedge ddr_clk); wr_fsync = 1'b1;
    @(negedge ddr_clk); wr_fsync = 1'b0;
  endtask

  task automatic drive_line(input int b, input bit gap);
    for (int i = 0; i < 1920; i++) begin
      @(negedge ddr_clk);
      if (gap && (i % 97) == 50) begin
        wr_en = 1'b0;
        repeat (3) @(negedge ddr_clk);
      end
      wr_en   = 1'b1;
      wr_data = 16'(b + i);
    end
    @(negedge ddr_clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [26:0] exp);
    int n = 0;
    while (ddr_wreq !== 1'b1 && n < 20) begin
      @(negedge ddr_clk);
      n++;
    end
    chk({tag, "_req"}, 128'(ddr_wreq), 1);
    chk({tag, "_addr"}, 128'(ddr_waddr), 128'(exp));
    @(negedge ddr_clk);
  endtask

  task automatic no_req(input string tag);
    int c = 0;
    repeat (20) begin
      @(negedge ddr_clk);
      if (ddr_wreq !== 1'b0) c++;
    end
    chk(tag, 128'(c), 0);
  endtask

  task automatic drain(input string tag, input int b, input bit fs);
    int bad = 0;
    for (int i = 0; i <= 240; i++) begin
      @(negedge ddr_clk);
      if (i > 0) beats[i-1] = ddr_wdata;
      ddr_wdata_req = (i < 240);
    end
    ddr_wdone = 1'b1;
    wr_fsync  = fs;
    @(negedge ddr_clk);
    ddr_wdone = 1'b0;
    wr_fsync  = 1'b0;
    for (int j = 0; j < 240; j++)
      if (beats[j] !== exp_word(b, j)) bad++;
    chk({tag, "_beats"}, 128'(bad), 0);
  endtask

  initial begin
    int c;
    ddr_rstn = 1'b0; wr_fsync = 1'b0; wr_en = 1'b0; wr_data = '0;
    init_done = 1'b1; ddr_wrdy = 1'b1; ddr_wdata_req = 1'b0;
    ddr_wdone = 1'b0;
    repeat (3) @(negedge ddr_clk);
    chk("rst_wreq", 128'(ddr_wreq), 0);
    chk("rst_waddr", 128'(ddr_waddr), 0);
    chk("rst_fdone", 128'(frame_done), 0);
    chk("rst_ovf", 128'(overflow), 0);
    chk("rst_wdata", ddr_wdata, 0);
    chk("wr_len", 128'(ddr_wr_len), 240);
    ddr_rstn = 1'b1;

    // first line, pixels 0..1919 with gaps, bank bit 1
    fsync_pulse();
    drive_line(0, 1'b1);
    chk("l0_pre", 128'(ddr_wreq), 0);
    @(negedge ddr_clk);
    chk("l0_rise", 128'(ddr_wreq), 1);
    chk("l0_addr", 128'(ddr_waddr), 128'h400_0000);
    @(negedge ddr_clk);
    chk("l0_one", 128'(ddr_wreq), 0);
    drain("l0", 0, 1'b0);
    chk("l0_beat0", beats[0], 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("l0_beat239", beats[239], 128'h077F_077E_077D_077C_077B_077A_0779_0778);

    // controller stalls the request for 50 cycles
    ddr_wrdy = 1'b0;
    drive_line(2000, 1'b0);
    @(negedge ddr_clk);
    chk("l1_rise", 128'(ddr_wreq), 1);
    chk("l1_addr", 128'(ddr_waddr), 128'h400_0780);
    c = 0;
    repeat (50) begin
      @(negedge ddr_clk);
      if (ddr_wreq === 1'b1 && ddr_waddr === 27'h400_0780) c++;
    end
    chk("l1_hold", 128'(c), 50);
    ddr_wrdy = 1'b1;
    @(negedge ddr_clk);
    chk("l1_data", 128'(ddr_wreq), 0);
    drain("l1", 2000, 1'b0);

    // overflow: drain stalled, third line has nowhere to go
    fsync_pulse();
    drive_line(3000, 1'b0);
    wait_req("ovA", 27'h000_0000);
    drive_line(4000, 1'b0);
    chk("ovB_flag", 128'(overflow), 0);
    drive_line(5000, 1'b0);
    chk("ovC_flag", 128'(overflow), 1);
    drain("ovA", 3000, 1'b0);
    wait_req("ovB", 27'h000_0780);
    drain("ovB", 4000, 1'b0);
    chk("ov_sticky", 128'(overflow), 1);
    fsync_pulse();
    @(negedge ddr_clk);
    chk("ov_clear", 128'(overflow), 0);

    // init_done gating
    init_done = 1'b0;
    drive_line(6000, 1'b0);
    no_req("init_block");
    init_done = 1'b1;
    @(negedge ddr_clk);
    chk("init_rise", 128'(ddr_wreq), 1);
    chk("init_addr", 128'(ddr_waddr), 128'h400_0000);
    @(negedge ddr_clk);
    drain("init", 6000, 1'b0);

    // fsync lands on the same cycle as wdone
    drive_line(7000, 1'b0);
    wait_req("col", 27'h400_0780);
    drain("col", 7000, 1'b1);
    drive_line(8000, 1'b0);
    wait_req("f2l0", 27'h000_0000);
    drain("f2l0", 8000, 1'b0);

    // rest of a 4-line frame
    drive_line(9000, 1'b0);
    wait_req("f2l1", 27'h000_0780);
    drain("f2l1", 9000, 1'b0);
    drive_line(10000, 1'b0);
    wait_req("f2l2", 27'h000_0F00);
    drain("f2l2", 10000, 1'b0);
    @(negedge ddr_clk);
    chk("fd_before", 128'(fd_cnt), 0);
    drive_line(11000, 1'b0);
    wait_req("f2l3", 27'h000_1680);
    drain("f2l3", 11000, 1'b0);
    @(negedge ddr_clk);
    chk("fd_after", 128'(fd_cnt), 1);
    drive_line(12000, 1'b0);
    no_req("f2_extra");
    fsync_pulse();
    drive_line(13000, 1'b0);
    wait_req("f3l0", 27'h400_0000);
    drain("f3l0", 13000, 1'b0);

    // reset in the middle of a burst
    drive_line(14000, 1'b0);
    wait_req("rb", 27'h400_0780);
    repeat (10) begin
      @(negedge ddr_clk);
      ddr_wdata_req = 1'b1;
    end
    @(negedge ddr_clk);
    ddr_wdata_req = 1'b0;
    ddr_rstn = 1'b0;
    @(negedge ddr_clk);
    chk("rb_wreq", 128'(ddr_wreq), 0);
    chk("rb_waddr", 128'(ddr_waddr), 0);
    chk("rb_wdata", ddr_wdata, 0);
    ddr_rstn = 1'b1;
    drive_line(15000, 1'b0);
    no_req("rb_nosync");
    fsync_pulse();
    drive_line(16000, 1'b0);
    wait_req("rbl0", 27'h400_0000);
    drain("rbl0", 16000, 1'b0);
    @(negedge ddr_clk);
    chk("fd_final", 128'(fd_cnt), 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
